axi4l_gpio: RTL and testbench
=============================

AXI4L_GPIO -- requirements
Module: axi4l_gpio

Interface
REQ-001 Parameter: NGPIO, default 32, number of GPIO pins (1..32).
REQ-002 aclk  in  1  single clock; all state on its rising edge.
REQ-003 areset  in  1  reset, asynchronous, active-high.
REQ-004 awvalid/awready  in/out  1/1; awaddr  in  32; awprot  in  3 (ignored): AXI4-Lite write address channel, responder side.
REQ-005 wvalid/wready  in/out  1/1; wdata  in  32; wstrb  in  4: write data channel.
REQ-006 bvalid/bready  out/in  1/1; bresp  out  2: write response channel.
REQ-007 arvalid/arready  in/out  1/1; araddr  in  32; arprot  in  3 (ignored): read address channel.
REQ-008 rvalid/rready  out/in  1/1; rdata  out  32; rresp  out  2: read data channel.
REQ-009 gpio_i  in  NGPIO  asynchronous pin inputs.
REQ-010 gpio_o  out  NGPIO  pin output values (= DOUT).
REQ-011 gpio_oe  out  NGPIO  per-pin output enable (= DIR).
REQ-012 irq  out  1  level interrupt, registered.

Function
REQ-013 Register map decoded from addr[4:2] only: 0x00 DOUT RW, 0x04 DIR RW, 0x08 DIN RO, 0x0C IRQ_STAT W1C, 0x10 IRQ_EN RW; addr[1:0] and addr[31:5] ignored.
REQ-014 Bits at and above NGPIO read 0 and ignore writes.
REQ-015 Write path: AW and W accepted independently; awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
REQ-016 Held AW/W registered on handshake; write commits in the cycle both are present (held or handshaking that cycle); bvalid asserts the following cycle.
REQ-017 Minimum write latency: AW+W handshake in cycle N -> bvalid in N+1; one write outstanding at most.
REQ-018 bvalid, bresp stable until bready; bvalid deasserts the cycle after bvalid&&bready; held flags clear on commit.
REQ-019 Writes honour wstrb per byte; wstrb=0 commits nothing yet returns OKAY.
REQ-020 Read path: arready = !rvalid; on AR handshake in cycle N, rvalid and rdata asserted in N+1, held stable until rready.
REQ-021 Read and write paths independent; read accepted same cycle as write commit to same register returns pre-write value.
REQ-022 Unmapped offset (0x14-0x1C) or write to DIN: bresp/rresp = SLVERR (2'b10), no state change, rdata = 0; mapped accesses OKAY (2'b00).
REQ-023 gpio_i passes through a 2-flop synchronizer; DIN returns second-stage value (2-cycle latency plus read latency).

Reset
REQ-024 On areset: awready, wready, arready = 0 while asserted, 1 from first clock after release; bvalid, rvalid, irq = 0; bresp, rresp, rdata = 0.
REQ-025 On areset: DOUT, DIR, IRQ_STAT, IRQ_EN, synchronizer and held AW/W state = 0; gpio_o, gpio_oe = 0.
REQ-026 Reset mid-transaction discards held AW/W and pending responses; no response issued after release.

Configuration
REQ-027 Macro GPIO_IRQ_EN defined: rising edge of synchronized input (prev 0, now 1) sets IRQ_STAT bit; irq = |(IRQ_STAT & IRQ_EN) registered one cycle.
REQ-028 W1C write to IRQ_STAT clears bits with wdata=1; simultaneous edge-set and clear on same bit: set wins.
REQ-029 Macro GPIO_IRQ_EN undefined: 0x0C and 0x10 are unmapped (SLVERR), irq tied 0, no edge logic.

Verification
REQ-030 AW 0x00 and W 0x0000_00A5 strb 0x1 same cycle -> bvalid next cycle, bresp 0, gpio_o = 0x0000_00A5.
REQ-031 W first, AW 3 cycles later, bready low 4 cycles -> awready/wready low while bvalid held, single response, DIR updated once.
REQ-032 gpio_i = 0x0000_0003 stable, read 0x08 after 3 cycles -> rdata 0x0000_0003, rresp 0.
REQ-033 Read 0x18 and write 0x08 -> rresp 2'b10 rdata 0, bresp 2'b10, DIN unaffected.
REQ-034 (GPIO_IRQ_EN) IRQ_EN=0x1, gpio_i[0] 0->1 -> IRQ_STAT=0x1, irq=1; write 0x1 to 0x0C -> irq=0.
REQ-035 areset asserted with bvalid pending -> bvalid 0 immediately, no B response after release, DOUT=0.

Source files
------------

// File: rtl/axi4l_gpio_if.sv
// AXI4-Lite bus bundle for the GPIO block: five channels, 32-bit address/data.
interface axi4l_gpio_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4l_gpio.sv
// AXI4-Lite GPIO: DOUT/DIR/DIN registers with a 2-flop input synchronizer.
// Optional edge interrupt (IRQ_STAT/IRQ_EN, irq output) enabled by defining GPIO_IRQ_EN.
module axi4l_gpio #(
  parameter int NGPIO = 32
) (
  input  logic             aclk,
  input  logic             areset,
  axi4l_gpio_if.slave      bus,
  input  logic [NGPIO-1:0] gpio_i,
  output logic [NGPIO-1:0] gpio_o,
  output logic [NGPIO-1:0] gpio_oe,
  output logic             irq
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic wr_mapped(input logic [2:0] idx);
    logic m;
    case (idx)
      3'd0, 3'd1: m = 1'b1;
`ifdef GPIO_IRQ_EN
      3'd3, 3'd4: m = 1'b1;
`endif
      default:    m = 1'b0;
    endcase
    return m;
  endfunction

  logic             live;
  logic             aw_held, w_held;
  logic [2:0]       aw_idx_q;
  logic [31:0]      w_data_q;
  logic [3:0]       w_strb_q;
  logic             bvalid_q, rvalid_q;
  logic [1:0]       bresp_q, rresp_q;
  logic [31:0]      rdata_q;
  logic [NGPIO-1:0] dout, dir, sync_p0, sync_p1;

  logic             awready_c, wready_c, arready_c;
  logic             aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
  logic [2:0]       wr_idx;
  logic [31:0]      wr_data, byte_m, wr_bits, rd_val;
  logic [3:0]       wr_strb;
  logic [NGPIO-1:0] wb_set, wb_msk;

`ifdef GPIO_IRQ_EN
  logic [NGPIO-1:0] irq_stat, irq_en, sync_prev;
`endif

  // live gates the ready outputs low until the first clock after reset release
  assign awready_c   = live && !aw_held && !bvalid_q;
  assign wready_c    = live && !w_held && !bvalid_q;
  assign arready_c   = live && !rvalid_q;
  assign bus.awready = awready_c;
  assign bus.wready  = wready_c;
  assign bus.arready = arready_c;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;
  assign gpio_o      = dout;
  assign gpio_oe     = dir;

  always_comb begin
    aw_hs   = bus.awvalid && awready_c;
    w_hs    = bus.wvalid && wready_c;
    ar_hs   = bus.arvalid && arready_c;
    wr_idx  = aw_held ? aw_idx_q : bus.awaddr[4:2];
    wr_data = w_held ? w_data_q : bus.wdata;
    wr_strb = w_held ? w_strb_q : bus.wstrb;
    commit  = (aw_held || aw_hs) && (w_held || w_hs);
    wr_ok   = wr_mapped(wr_idx);
    byte_m  = strb_mask(wr_strb);
    wr_bits = wr_data & byte_m;
    wb_set  = wr_bits[NGPIO-1:0];
    wb_msk  = byte_m[NGPIO-1:0];
  end

  always_comb begin
    rd_ok  = 1'b1;
    rd_val = '0;
    case (bus.araddr[4:2])
      3'd0:    rd_val = 32'(dout);
      3'd1:    rd_val = 32'(dir);
      3'd2:    rd_val = 32'(sync_p1);
`ifdef GPIO_IRQ_EN
      3'd3:    rd_val = 32'(irq_stat);
      3'd4:    rd_val = 32'(irq_en);
`endif
      default: rd_ok = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      live     <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      dout     <= '0;
      dir      <= '0;
      sync_p0  <= '0;
      sync_p1  <= '0;
    end else begin
      live    <= 1'b1;
      sync_p0 <= gpio_i;
      sync_p1 <= sync_p0;
      // write side: a commit consumes whatever halves are held or arriving now
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_idx == 3'd0) dout <= (dout & ~wb_msk) | wb_set;
        if (wr_idx == 3'd1) dir  <= (dir & ~wb_msk) | wb_set;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= bus.awaddr[4:2];
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= bus.wdata;
          w_strb_q <= bus.wstrb;
        end
        if (bvalid_q && bus.bready) bvalid_q <= 1'b0;
      end
      // read side samples registers before any same-edge write lands
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_ok ? rd_val : 32'd0;
        rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && bus.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

`ifdef GPIO_IRQ_EN
  // edge set takes priority over a W1C clear of the same bit
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync_prev <= '0;
      irq_stat  <= '0;
      irq_en    <= '0;
      irq       <= 1'b0;
    end else begin
      sync_prev <= sync_p1;
      irq_stat  <= (irq_stat & ~((commit && wr_idx == 3'd3) ? wb_set : '0)) | (sync_p1 & ~sync_prev);
      if (commit && wr_idx == 3'd4) irq_en <= (irq_en & ~wb_msk) | wb_set;
      irq       <= |(irq_stat & irq_en);
    end
  end
`else
  assign irq = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.awaddr[31:5], bus.awaddr[1:0], bus.araddr[31:5], bus.araddr[1:0],
                         bus.awprot, bus.arprot};
endmodule

// File: tb/tb_axi4l_gpio.sv
// Randomized bench for axi4l_gpio (NGPIO=20) against a register-map reference model.
module tb_axi4l_gpio;
  localparam int          NG = 20;
  localparam logic [31:0] GM = 32'h000F_FFFF;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [NG-1:0] gpio_i = '0;
  wire  [NG-1:0] gpio_o, gpio_oe;
  wire           irq;
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;

  logic [31:0] m_dout = '0, m_dir = '0, m_stat = '0, m_en = '0, m_gpio = '0;

  axi4l_gpio_if bus();

  axi4l_gpio #(.NGPIO(NG)) dut (
    .aclk(aclk), .areset(areset), .bus(bus),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc = cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bytes_of(input logic [3:0] s);
    logic [31:0] m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  task automatic model_write(input logic [31:0] addr, data, input logic [3:0] strb,
                             output logic [1:0] resp);
    logic [31:0] m = bytes_of(strb) & GM;
    resp = 2'b00;
    case (addr[4:2])
      3'd0: m_dout = (m_dout & ~m) | (data & m);
      3'd1: m_dir  = (m_dir & ~m) | (data & m);
`ifdef GPIO_IRQ_EN
      3'd3: m_stat = m_stat & ~(data & m);
      3'd4: m_en   = (m_en & ~m) | (data & m);
`endif
      default: resp = 2'b10;
    endcase
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    resp = 2'b00;
    data = '0;
    case (addr[4:2])
      3'd0: data = m_dout;
      3'd1: data = m_dir;
      3'd2: data = m_gpio & GM;
`ifdef GPIO_IRQ_EN
      3'd3: data = m_stat;
      3'd4: data = m_en;
`endif
      default: resp = 2'b10;
    endcase
  endtask

  task automatic model_reset();
    m_dout = '0; m_dir = '0; m_stat = '0; m_en = '0;
  endtask

  task automatic check_pins(input string tag);
    check({tag, "_gpio_o"}, 32'(gpio_o), m_dout);
    check({tag, "_gpio_oe"}, 32'(gpio_oe), m_dir);
    check({tag, "_irq"}, 32'(irq), 32'(|(m_stat & m_en)));
  endtask

  task automatic set_gpio(input logic [31:0] v);
    gpio_i = v[NG-1:0];
`ifdef GPIO_IRQ_EN
    m_stat = m_stat | (v & ~m_gpio & GM);
`endif
    m_gpio = v & GM;
    repeat (4) @(negedge aclk);
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic axi_write(input logic [31:0] addr, data, input logic [3:0] strb,
                           input int aw_d, w_d, b_d, output logic [1:0] resp);
    int aw_c = -1, w_c = -1, b_c = -2;
    logic [31:0] r = $urandom;
    fork
      begin
        int t = 0;
        repeat (aw_d) @(negedge aclk);
        bus.awvalid = 1'b1; bus.awaddr = addr; bus.awprot = r[2:0];
        while (!bus.awready && t < 30) begin @(negedge aclk); t++; end
        if (!bus.awready) check("aw_timeout", 0, 1);
        else begin @(posedge aclk); @(negedge aclk); aw_c = cyc; end
        bus.awvalid = 1'b0;
      end
      begin
        int t = 0;
        repeat (w_d) @(negedge aclk);
        bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb;
        while (!bus.wready && t < 30) begin @(negedge aclk); t++; end
        if (!bus.wready) check("w_timeout", 0, 1);
        else begin @(posedge aclk); @(negedge aclk); w_c = cyc; end
        bus.wvalid = 1'b0;
      end
      begin
        int t = 0;
        while (!bus.bvalid && t < 40) begin @(negedge aclk); t++; end
        if (!bus.bvalid) begin
          check("b_timeout", 0, 1);
          resp = 2'b11;
        end else begin
          b_c = cyc;
          resp = bus.bresp;
          repeat (b_d) begin
            check("b_hold", 32'(bus.bvalid), 1);
            check("b_resp_stable", 32'(bus.bresp), 32'(resp));
            check("aw_blocked", 32'(bus.awready), 0);
            check("w_blocked", 32'(bus.wready), 0);
            @(negedge aclk);
          end
          bus.bready = 1'b1;
          @(posedge aclk);
          @(negedge aclk);
          bus.bready = 1'b0;
          check("b_drop", 32'(bus.bvalid), 0);
        end
      end
    join
    check("w_latency", 32'(b_c), 32'((aw_c > w_c) ? aw_c : w_c));
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_d,
                          output logic [31:0] data, output logic [1:0] resp);
    int t = 0;
    logic [31:0] r = $urandom;
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arprot = r[2:0];
    while (!bus.arready && t < 30) begin @(negedge aclk); t++; end
    if (!bus.arready) begin
      check("ar_timeout", 0, 1);
      bus.arvalid = 1'b0;
      data = '1; resp = 2'b11;
    end else begin
      @(posedge aclk);
      @(negedge aclk);
      bus.arvalid = 1'b0;
      check("r_latency", 32'(bus.rvalid), 1);
      data = bus.rdata;
      resp = bus.rresp;
      repeat (r_d) begin
        check("ar_blocked", 32'(bus.arready), 0);
        check("r_hold", 32'(bus.rvalid), 1);
        check("r_data_stable", bus.rdata, data);
        @(negedge aclk);
      end
      bus.rready = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      bus.rready = 1'b0;
      check("r_drop", 32'(bus.rvalid), 0);
    end
  endtask

  task automatic wr_check(input string tag, input logic [31:0] addr, data, input logic [3:0] strb,
                          input int aw_d, w_d, b_d);
    logic [1:0] er, gr;
    model_write(addr, data, strb, er);
    axi_write(addr, data, strb, aw_d, w_d, b_d, gr);
    check({tag, "_bresp"}, 32'(gr), 32'(er));
    check_pins(tag);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input int r_d,
                          output logic [31:0] got);
    logic [31:0] ed;
    logic [1:0]  er, gr;
    model_read(addr, ed, er);
    axi_read(addr, r_d, got, gr);
    check({tag, "_rdata"}, got, ed);
    check({tag, "_rresp"}, 32'(gr), 32'(er));
  endtask

  initial begin
    logic [31:0] d, old, r1, r2;
    logic [1:0]  br, rr, er;
    bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0; bus.rready = 0;

    // reset state
    repeat (3) @(negedge aclk);
    check("rst_awready", 32'(bus.awready), 0);
    check("rst_wready", 32'(bus.wready), 0);
    check("rst_arready", 32'(bus.arready), 0);
    check("rst_bvalid", 32'(bus.bvalid), 0);
    check("rst_rvalid", 32'(bus.rvalid), 0);
    check("rst_rdata", bus.rdata, 0);
    check_pins("rst");
    areset = 1'b0;
    check("rel_awready", 32'(bus.awready), 0);
    @(negedge aclk);
    check("live_awready", 32'(bus.awready), 1);
    check("live_wready", 32'(bus.wready), 1);
    check("live_arready", 32'(bus.arready), 1);

    // single-byte write, AW and W together
    wr_check("dout_a5", 32'h0, 32'h0000_00A5, 4'h1, 0, 0, 0);
    check("dout_a5_const", 32'(gpio_o), 32'h0000_00A5);

    // W first, AW 3 cycles later, slow bready
    d = $urandom;
    wr_check("dir_late_aw", 32'h4, d, 4'hF, 3, 0, 4);
    repeat (3) begin
      check("no_extra_b", 32'(bus.bvalid), 0);
      @(negedge aclk);
    end
    check("dir_once", 32'(gpio_oe), d & GM);

    // bits above NGPIO read 0, strb=0 is a no-op
    wr_check("dout_all", 32'h0, 32'hFFFF_FFFF, 4'hF, 0, 1, 0);
    rd_check("dout_all_rd", 32'h0, 0, r1);
    check("dout_all_const", r1, 32'h000F_FFFF);
    wr_check("strb0", 32'h0, 32'h0, 4'h0, 0, 0, 0);
    check("strb0_const", 32'(gpio_o), 32'h000F_FFFF);
    wr_check("alias", 32'hABCD_E023, 32'h1234_5678, 4'h3, 1, 0, 1);

    // synchronized input read
    set_gpio(32'h3);
    rd_check("din", 32'h8, 0, r1);
    check("din_const", r1, 32'h3);

    // unmapped read, DIN write
    rd_check("unmapped_rd", 32'h18, 2, r1);
    check("unmapped_rd_data", r1, 0);
    wr_check("din_wr", 32'h8, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    rd_check("din_after", 32'h8, 0, r1);
    check("din_after_const", r1, 32'h3);
    wr_check("irq_reg_wr", 32'h10, 32'h0, 4'hF, 0, 0, 0);
    rd_check("irq_reg_rd", 32'h0C, 0, r1);

    // read and write to the same register in the same cycle
    old = m_dout;
    d = $urandom;
    fork
      axi_write(32'h0, d, 4'hF, 0, 0, 0, br);
      axi_read(32'h0, 0, r2, rr);
    join
    check("rd_pre_wr", r2, old);
    model_write(32'h0, d, 4'hF, er);
    check("rd_pre_wr_bresp", 32'(br), 32'(er));
    check_pins("rd_pre_wr");

`ifdef GPIO_IRQ_EN
    set_gpio(32'h0);
    wr_check("stat_clr", 32'h0C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    wr_check("en1", 32'h10, 32'h1, 4'hF, 0, 0, 0);
    check("irq_idle", 32'(irq), 0);
    set_gpio(32'h1);
    check("irq_set", 32'(irq), 1);
    rd_check("stat_rd", 32'h0C, 0, r1);
    check("stat_const", r1, 32'h1);
    wr_check("w1c", 32'h0C, 32'h1, 4'h1, 0, 0, 0);
    check("irq_clr", 32'(irq), 0);
`else
    check("irq_tied", 32'(irq), 0);
`endif

    // reset while a response is pending
    set_gpio(32'h0);
    bus.awvalid = 1; bus.awaddr = 32'h0; bus.wvalid = 1; bus.wdata = 32'h5A; bus.wstrb = 4'hF;
    @(posedge aclk);
    @(negedge aclk);
    bus.awvalid = 0; bus.wvalid = 0;
    check("pre_rst_bvalid", 32'(bus.bvalid), 1);
    check("pre_rst_dout", 32'(gpio_o), 32'h5A);
    areset = 1'b1;
    #1;
    model_reset();
    check("rst_bvalid_now", 32'(bus.bvalid), 0);
    check_pins("rst_mid");
    @(negedge aclk);
    areset = 1'b0;
    bus.bready = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      check("no_b_after_rst", 32'(bus.bvalid), 0);
    end
    bus.bready = 1'b0;

    // reset discards a held AW
    bus.awvalid = 1; bus.awaddr = 32'h4;
    @(posedge aclk);
    @(negedge aclk);
    bus.awvalid = 0;
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    wr_check("held_discard", 32'h0, 32'h33, 4'hF, 3, 0, 0);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a = $urandom;
      logic [31:0] k = $urandom;
      int op = $urandom_range(0, 9);
      a[4:2] = k[2:0];
      if (op < 5)
        wr_check("rnd_wr", a, $urandom, k[7:4], $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3));
      else if (op < 9)
        rd_check("rnd_rd", a, $urandom_range(0, 3), r1);
      else begin
        set_gpio($urandom);
        check_pins("rnd_gpio");
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
